// File: rtl/sd_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sd_clock_ctrl
// Summary  : SD card clock generator with power-up init clock, run gating
//            and glitch-free slow/fast rate switching with edge strobes.
// Revision : 1.0
// ============================================================================
module sd_clock_ctrl #(
    parameter int SLOW_DIV    = 128,
    parameter int FAST_DIV    = 2,
    parameter int INIT_CYCLES = 74
) (
    input  logic iclk,
    input  logic irst_n,
    input  logic ien,
    input  logic isel_fast,
    output logic osd_clk,
    output logic orise,
    output logic ofall,
    output logic ofast,
    output logic oinit_done
);

    localparam int C_HC_W = (SLOW_DIV / 2 > 1) ? $clog2(SLOW_DIV / 2) : 1;
    localparam int C_RC_W = $clog2(INIT_CYCLES + 1);

    localparam logic [C_HC_W-1:0] C_SLOW_LAST  = C_HC_W'(SLOW_DIV / 2 - 1);
    localparam logic [C_HC_W-1:0] C_FAST_LAST  = C_HC_W'(FAST_DIV / 2 - 1);
    localparam logic [C_RC_W-1:0] C_INIT_RISES = C_RC_W'(INIT_CYCLES);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [C_HC_W-1:0]   hc_q, hc_d;
    logic [C_RC_W-1:0]   rc_q, rc_d;
    logic                clk_q, clk_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;
    logic                fast_q, fast_d;
    logic                done_q, done_d;

    logic [C_HC_W-1:0]   w_last;
    logic                w_tick;
    logic                w_rising;
    logic                w_falling;

    // fast_q is forced to 0 through INIT, so the slow limit applies there.
    assign w_last    = fast_q ? C_FAST_LAST : C_SLOW_LAST;
    assign w_tick    = (hc_q == w_last);
    assign w_rising  = w_tick & ~clk_q;
    assign w_falling = w_tick &  clk_q;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q <= ST_INIT;
            hc_q    <= '0;
            rc_q    <= '0;
            clk_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            fast_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hc_q    <= hc_d;
            rc_q    <= rc_d;
            clk_q   <= clk_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            fast_q  <= fast_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hc_d    = hc_q;
        rc_d    = rc_q;
        clk_d   = clk_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        fast_d  = fast_q;
        done_d  = done_q;

        if (state_q != ST_IDLE) begin
            if (w_tick) begin
                hc_d   = '0;
                clk_d  = ~clk_q;
                rise_d = ~clk_q;
                fall_d =  clk_q;
            end else begin
                hc_d = hc_q + 1'b1;
            end
        end

        case (state_q)
            ST_INIT: begin
                if (w_rising) begin
                    rc_d = rc_q + 1'b1;
                end
                if (w_falling && (rc_q == C_INIT_RISES)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_RUN: begin
                // Requests are honoured only as the clock goes low, so no phase is cut short.
                if (w_falling) begin
                    if (!ien) begin
                        state_d = ST_IDLE;
                    end else if (isel_fast != fast_q) begin
                        fast_d = isel_fast;
                    end
                end
            end
            ST_IDLE: begin
                clk_d = 1'b0;
                hc_d  = '0;
                if (ien) begin
                    state_d = ST_RUN;
                    fast_d  = isel_fast;
                end
            end
            default: begin
                state_d = ST_INIT;
                clk_d   = 1'b0;
                hc_d    = '0;
                rc_d    = '0;
                rise_d  = 1'b0;
                fall_d  = 1'b0;
            end
        endcase
    end

    assign osd_clk    = clk_q;
    assign orise      = rise_q;
    assign ofall      = fall_q;
    assign ofast      = fast_q;
    assign oinit_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_clock_ctrl
// Summary  : Self-checking bench for sd_clock_ctrl against a timestamp-based
//            reference model of the SD clock schedule.
// Revision : 1.0
// ============================================================================
module tb_sd_clock_ctrl;

    localparam int SLOW_DIV    = 128;
    localparam int FAST_DIV    = 2;
    localparam int INIT_CYCLES = 74;
    localparam int H_SLOW      = SLOW_DIV / 2;
    localparam int INIT_EDGE   = INIT_CYCLES * SLOW_DIV;

    localparam int MODE_INIT = 0;
    localparam int MODE_IDLE = 1;
    localparam int MODE_RUN  = 2;

    logic iclk      = 1'b0;
    logic irst_n    = 1'b1;
    logic ien       = 1'b0;
    logic isel_fast = 1'b0;
    logic osd_clk, orise, ofall, ofast, oinit_done;

    int total  = 0;
    int bad    = 0;
    int edge_n = 0;

    // Reference model: absolute edge number of the next toggle, not a counter.
    int m_cyc   = 0;
    int m_next  = H_SLOW;
    int m_mode  = MODE_INIT;
    int m_rises = 0;
    bit m_clk   = 1'b0;
    bit m_rise  = 1'b0;
    bit m_fall  = 1'b0;
    bit m_fast  = 1'b0;
    bit m_done  = 1'b0;

    logic [4:0] dut_v;
    logic [4:0] mod_v;
    assign dut_v = {osd_clk, orise, ofall, ofast, oinit_done};
    assign mod_v = {m_clk, m_rise, m_fall, m_fast, m_done};

    sd_clock_ctrl #(
        .SLOW_DIV    (SLOW_DIV),
        .FAST_DIV    (FAST_DIV),
        .INIT_CYCLES (INIT_CYCLES)
    ) u_dut (
        .iclk       (iclk),
        .irst_n     (irst_n),
        .ien        (ien),
        .isel_fast  (isel_fast),
        .osd_clk    (osd_clk),
        .orise      (orise),
        .ofall      (ofall),
        .ofast      (ofast),
        .oinit_done (oinit_done)
    );

    always #5 iclk = ~iclk;

    function automatic int half(input bit f);
        return f ? FAST_DIV / 2 : SLOW_DIV / 2;
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_next = H_SLOW; m_mode = MODE_INIT; m_rises = 0;
        m_clk = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_fast = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_step();
        m_cyc++;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (m_mode == MODE_IDLE) begin
            if (ien) begin
                m_mode = MODE_RUN;
                m_fast = isel_fast;
                m_next = m_cyc + half(m_fast);
            end
        end else if (m_cyc == m_next) begin
            m_clk = !m_clk;
            if (m_clk) begin
                m_rise = 1'b1;
                m_rises++;
            end else begin
                m_fall = 1'b1;
                if (m_mode == MODE_INIT) begin
                    if (m_rises == INIT_CYCLES) begin
                        m_mode = MODE_IDLE;
                        m_done = 1'b1;
                    end
                end else if (!ien) begin
                    m_mode = MODE_IDLE;
                end else begin
                    m_fast = isel_fast;
                end
            end
            m_next = m_cyc + half(m_fast);
        end
    endtask

    task automatic tick();
        @(posedge iclk);
        model_step();
        #1;
        edge_n++;
    endtask

    task automatic test_reset();
        ien = 1'b0; isel_fast = 1'b0;
        #1 irst_n = 1'b0;
        #2;
        total++; if (dut_v !== 5'b0) begin bad++; $display("FAIL reset_outputs got=%b want=00000", dut_v); end
        model_reset();
        repeat (3) @(negedge iclk);
        irst_n = 1'b1;
        edge_n = 0;
    endtask

    task automatic test_init_sequence();
        int first_rise, rises, done_edge;
        bit odd_fall;
        first_rise = 0; rises = 0; done_edge = 0; odd_fall = 1'b0;
        for (int i = 0; i < INIT_EDGE + 128; i++) begin
            tick();
            total++; if (dut_v !== mod_v) begin bad++; $display("FAIL init_track edge=%0d got=%b want=%b", edge_n, dut_v, mod_v); end
            if (orise) begin rises++; if (first_rise == 0) first_rise = edge_n; end
            if (ofall && (edge_n % SLOW_DIV) != 0) odd_fall = 1'b1;
            if (oinit_done && done_edge == 0) done_edge = edge_n;
        end
        total++; if (first_rise != H_SLOW) begin bad++; $display("FAIL init_first_rise got=%0d want=%0d", first_rise, H_SLOW); end
        total++; if (rises != INIT_CYCLES) begin bad++; $display("FAIL init_rise_count got=%0d want=%0d", rises, INIT_CYCLES); end
        total++; if (done_edge != INIT_EDGE) begin bad++; $display("FAIL init_done_edge got=%0d want=%0d", done_edge, INIT_EDGE); end
        total++; if (odd_fall) begin bad++; $display("FAIL init_fall_align got=misaligned want=multiple_of_%0d", SLOW_DIV); end
        total++; if (osd_clk !== 1'b0) begin bad++; $display("FAIL init_clock_parked got=%b want=0", osd_clk); end
    endtask

    task automatic test_slow_run();
        int k, last_rise, last_fall;
        ien = 1'b1; isel_fast = 1'b0;
        k = edge_n + 1; last_rise = -1; last_fall = -1;
        for (int i = 0; i < 700; i++) begin
            tick();
            total++; if (dut_v !== mod_v) begin bad++; $display("FAIL slow_track edge=%0d got=%b want=%b", edge_n, dut_v, mod_v); end
            if (orise) begin
                total++;
                if (last_rise < 0) begin
                    if (edge_n != k + H_SLOW) begin bad++; $display("FAIL slow_first_rise got=%0d want=%0d", edge_n, k + H_SLOW); end
                end else if (edge_n - last_fall != H_SLOW) begin
                    bad++; $display("FAIL slow_low_len got=%0d want=%0d", edge_n - last_fall, H_SLOW);
                end
                last_rise = edge_n;
            end
            if (ofall) begin
                total++; if (edge_n - last_rise != H_SLOW) begin bad++; $display("FAIL slow_high_len got=%0d want=%0d", edge_n - last_rise, H_SLOW); end
                last_fall = edge_n;
            end
        end
    endtask

    task automatic test_rate_switch();
        int r, f;
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            total++; if (dut_v !== mod_v) begin bad++; $display("FAIL switch_track edge=%0d got=%b want=%b", edge_n, dut_v, mod_v); end
            if (orise) found = 1'b1;
        end
        r = edge_n;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++; if (dut_v !== mod_v) begin bad++; $display("FAIL switch_track edge=%0d got=%b want=%b", edge_n, dut_v, mod_v); end
        end
        isel_fast = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            total++; if (dut_v !== mod_v) begin bad++; $display("FAIL switch_track edge=%0d got=%b want=%b", edge_n, dut_v, mod_v); end
            if (ofall) found = 1'b1;
        end
        total++; if (!found || edge_n - r != H_SLOW) begin bad++; $display("FAIL switch_high_kept got=%0d want=%0d", edge_n - r, H_SLOW); end
        total++; if (ofast !== 1'b1) begin bad++; $display("FAIL switch_ofast_at_fall got=%b want=1", ofast); end
        tick();
        total++; if (orise !== 1'b1 || osd_clk !== 1'b1) begin bad++; $display("FAIL fast_first_rise got=%b want=1", orise); end
        tick();
        total++; if (ofall !== 1'b1 || osd_clk !== 1'b0) begin bad++; $display("FAIL fast_first_fall got=%b want=1", ofall); end
        for (int i = 0; i < 20; i++) begin
            tick();
            total++; if (dut_v !== mod_v) begin bad++; $display("FAIL fast_track edge=%0d got=%b want=%b", edge_n, dut_v, mod_v); end
        end
        isel_fast = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            total++; if (dut_v !== mod_v) begin bad++; $display("FAIL back_track edge=%0d got=%b want=%b", edge_n, dut_v, mod_v); end
            if (ofall && !ofast) found = 1'b1;
        end
        f = edge_n;
        total++; if (!found) begin bad++; $display("FAIL back_switch_fall got=timeout want=fall_with_ofast_0"); end
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            total++; if (dut_v !== mod_v) begin bad++; $display("FAIL back_track edge=%0d got=%b want=%b", edge_n, dut_v, mod_v); end
            if (orise) found = 1'b1;
        end
        total++; if (!found || edge_n - f != H_SLOW) begin bad++; $display("FAIL back_first_low got=%0d want=%0d", edge_n - f, H_SLOW); end
    endtask

    task automatic test_stop_restart();
        int r, k;
        bit found, noisy;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            total++; if (dut_v !== mod_v) begin bad++; $display("FAIL stop_track edge=%0d got=%b want=%b", edge_n, dut_v, mod_v); end
            if (orise) found = 1'b1;
        end
        r = edge_n;
        repeat (10) tick();
        ien = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            total++; if (dut_v !== mod_v) begin bad++; $display("FAIL stop_track edge=%0d got=%b want=%b", edge_n, dut_v, mod_v); end
            if (ofall) found = 1'b1;
        end
        total++; if (!found || edge_n - r != H_SLOW) begin bad++; $display("FAIL stop_high_len got=%0d want=%0d", edge_n - r, H_SLOW); end
        noisy = 1'b0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (osd_clk || orise || ofall) noisy = 1'b1;
        end
        total++; if (noisy) begin bad++; $display("FAIL stop_idle_quiet got=activity want=none"); end
        ien = 1'b1; isel_fast = 1'b0;
        k = edge_n + 1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (orise) found = 1'b1;
        end
        total++; if (!found || edge_n != k + H_SLOW) begin bad++; $display("FAIL restart_slow_rise got=%0d want=%0d", edge_n, k + H_SLOW); end
        ien = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (ofall) found = 1'b1;
        end
        repeat (20) tick();
        ien = 1'b1; isel_fast = 1'b1;
        k = edge_n + 1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            total++; if (dut_v !== mod_v) begin bad++; $display("FAIL restart_track edge=%0d got=%b want=%b", edge_n, dut_v, mod_v); end
            if (orise) found = 1'b1;
        end
        total++; if (!found || edge_n != k + 1 || ofast !== 1'b1) begin bad++; $display("FAIL restart_fast_rise got=%0d want=%0d", edge_n, k + 1); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 7; i++) begin
            tick();
            total++; if (dut_v !== mod_v) begin bad++; $display("FAIL pre_reset_track edge=%0d got=%b want=%b", edge_n, dut_v, mod_v); end
        end
        #2 irst_n = 1'b0;
        #1;
        total++; if (dut_v !== 5'b0) begin bad++; $display("FAIL async_reset got=%b want=00000", dut_v); end
        model_reset();
        repeat (2) @(negedge iclk);
        irst_n = 1'b1;
        edge_n = 0;
    endtask

    task automatic test_init_ignores_inputs();
        int first_rise, rises, done_edge;
        bit fast_seen;
        ien = 1'b1; isel_fast = 1'b1;
        first_rise = 0; rises = 0; done_edge = 0; fast_seen = 1'b0;
        for (int i = 0; i < INIT_EDGE + 2; i++) begin
            tick();
            total++; if (dut_v !== mod_v) begin bad++; $display("FAIL reinit_track edge=%0d got=%b want=%b", edge_n, dut_v, mod_v); end
            if (orise && edge_n <= INIT_EDGE) begin rises++; if (first_rise == 0) first_rise = edge_n; end
            if (ofast && edge_n <= INIT_EDGE) fast_seen = 1'b1;
            if (oinit_done && done_edge == 0) done_edge = edge_n;
        end
        total++; if (first_rise != H_SLOW) begin bad++; $display("FAIL reinit_first_rise got=%0d want=%0d", first_rise, H_SLOW); end
        total++; if (rises != INIT_CYCLES) begin bad++; $display("FAIL reinit_rise_count got=%0d want=%0d", rises, INIT_CYCLES); end
        total++; if (done_edge != INIT_EDGE) begin bad++; $display("FAIL reinit_done_edge got=%0d want=%0d", done_edge, INIT_EDGE); end
        total++; if (fast_seen) begin bad++; $display("FAIL reinit_rate got=fast want=slow"); end
        total++; if (orise !== 1'b1 || ofast !== 1'b1) begin bad++; $display("FAIL reinit_fast_entry got=rise%b_fast%b want=rise1_fast1", orise, ofast); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) ien = ~ien;
            if ($urandom_range(0, 149) == 0) isel_fast = ~isel_fast;
            tick();
            total++; if (dut_v !== mod_v) begin bad++; $display("FAIL random_track edge=%0d got=%b want=%b", edge_n, dut_v, mod_v); end
            total++; if (orise && ofall) begin bad++; $display("FAIL strobe_exclusive edge=%0d got=11 want=not_both", edge_n); end
        end
    endtask

    initial begin
        test_reset();
        test_init_sequence();
        test_slow_run();
        test_rate_switch();
        test_stop_restart();
        test_async_reset();
        test_init_ignores_inputs();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
